// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the controller state encoding and the default operand width.
// No ports; imported by serial_add_ctrl.
package serial_add_ctrl_pkg;

  // Default operand/sum width in bits; legal range is 2..32.
  localparam int SAC_WIDTH_DEFAULT = 8;
  localparam int SAC_WIDTH_MIN     = 2;
  localparam int SAC_WIDTH_MAX     = 32;

  // 2'd3 is not a member: the controller treats it as illegal and
  // falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sac_state_e;

endpackage : serial_add_ctrl_pkg

// File: rtl/full_adder.sv
// Purpose : single-bit full adder cell, the datapath slice of the serial adder.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the cell has no handshake.
// Ports   : a_i, b_i, ci_i operand and carry-in bits; s_o sum bit; co_o carry-out bit.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial WIDTH-bit adder, one full_adder cell driven LSB first.
// Latency : start at edge E0, done high after edge E(WIDTH); one add per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; start while busy is dropped, not queued.
// Ports   : clk, reset (async, active-high); start/a/b/cin request and operands;
//           busy, done (1-cycle pulse), sum, cout, ovf registered results.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit counter only has to hold 0..WIDTH-1.
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if ((WIDTH < SAC_WIDTH_MIN) || (WIDTH > SAC_WIDTH_MAX)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be in 2..32");
  end

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  sac_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  // Holds the WIDTH-1 sum bits produced so far; the final bit comes
  // straight from the cell on the last SHIFT edge.
  logic [WIDTH-2:0] sum_sr_q;
  logic             carry_q;
  logic             msb_cin_q;

  // Registered outputs.
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // --------------------------------------------------------------------
  // Datapath: one full-adder slice
  // --------------------------------------------------------------------
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_sr_d;

  full_adder u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_c)
  );

  // New sum bit enters at the top; after WIDTH shifts bit 0 of the
  // result has walked down to the LSB.
  assign sum_sr_d = {fa_s, sum_sr_q};

  // --------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          sum_sr_q <= sum_sr_d[WIDTH-1:1];
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= fa_c;
          if (count_q == LAST_BIT) begin
            // carry_q is the carry into the MSB on this edge, fa_c the
            // carry out of it; their XOR is signed overflow.
            msb_cin_q <= carry_q;
            count_q   <= '0;
            sum_q     <= sum_sr_d;
            cout_q    <= fa_c;
            ovf_q     <= carry_q ^ fa_c;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          // Unreachable encoding: recover to a quiet idle.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          count_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // --------------------------------------------------------------------
  // Internal consistency properties
  // --------------------------------------------------------------------
  // done is a single-cycle pulse.
  a_done_pulse : assert property (@(posedge clk) disable iff (reset)
    done_q |=> !done_q);

  // done only ever appears while the controller reports busy.
  a_done_busy : assert property (@(posedge clk) disable iff (reset)
    done_q |-> busy_q);

  // The bit counter never passes the last bit position.
  a_count_rng : assert property (@(posedge clk) disable iff (reset)
    count_q <= LAST_BIT);

  // The latched MSB carry-in is consistent with the reported overflow.
  a_ovf_cons : assert property (@(posedge clk) disable iff (reset)
    done_q |-> (ovf_q == (msb_cin_q ^ cout_q)));

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WIDTH=8 instance signals
  logic        start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  // WIDTH=13 instance signals
  logic        start13, cin13, busy13, done13, cout13, ovf13;
  logic [12:0] a13, b13, sum13;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .reset(reset), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  // Observation views indexed by instance (0 = WIDTH 8, 1 = WIDTH 13).
  logic        obs_busy [2];
  logic        obs_done [2];
  logic        obs_cout [2];
  logic        obs_ovf  [2];
  logic [31:0] obs_sum  [2];
  always_comb begin
    obs_busy[0] = busy8;  obs_busy[1] = busy13;
    obs_done[0] = done8;  obs_done[1] = done13;
    obs_cout[0] = cout8;  obs_cout[1] = cout13;
    obs_ovf[0]  = ovf8;   obs_ovf[1]  = ovf13;
    obs_sum[0]  = 32'(sum8);
    obs_sum[1]  = 32'(sum13);
  end

  int checks = 0;
  int errors = 0;
  // Model-side value the sum output must hold between operations.
  logic [31:0] prev_exp [2];

  // Reference: plain integer addition modulo 2^w.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input bit cv, output logic [31:0] s, output bit co,
                                output bit ov);
    longint unsigned m, t;
    m  = (longint'(1) << w) - 1;
    t  = (longint'(av) & m) + (longint'(bv) & m) + longint'(cv);
    s  = 32'(t & m);
    co = ((t >> w) & 1) != 0;
    // Two same-signed operands producing a differently-signed result.
    ov = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
  endfunction

  task automatic drive(input int d, input bit st, input logic [31:0] av,
                       input logic [31:0] bv, input bit cv);
    if (d == 0) begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
    end else begin
      start13 = st; a13 = av[12:0]; b13 = bv[12:0]; cin13 = cv;
    end
  endtask

  // Issues one add from a negedge with the DUT idle and follows it to idle
  // again, returning what was observed. Ends on a negedge.
  task automatic run_op(input int d, input int w, input logic [31:0] av,
                        input logic [31:0] bv, input bit cv,
                        output logic [31:0] s, output bit co, output bit ov,
                        output int busy_n, output int done_k, output int done_n,
                        output bit stable);
    drive(d, 1'b1, av, bv, cv);
    @(negedge clk);
    // Captured operands only: scramble the inputs straight away.
    drive(d, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    busy_n = 0; done_k = -1; done_n = 0; stable = 1'b1;
    s = '0; co = 1'b0; ov = 1'b0;
    for (int k = 1; k <= w + 6; k++) begin
      if (obs_done[d]) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k; s = obs_sum[d]; co = obs_cout[d]; ov = obs_ovf[d];
        end
      end else if (done_k < 0 && obs_sum[d] !== prev_exp[d]) begin
        stable = 1'b0;
      end
      if (obs_busy[d]) busy_n++;
      if (done_k >= 0 && !obs_busy[d]) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({obs_busy[d], obs_done[d], obs_cout[d], obs_ovf[d]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags dut%0d got busy/done/cout/ovf=%b%b%b%b want 0000", d,
                 obs_busy[d], obs_done[d], obs_cout[d], obs_ovf[d]);
      end
      checks++;
      if (obs_sum[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_sum dut%0d got %h want 0", d, obs_sum[d]);
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", busy8, done8);
    end
    prev_exp[0] = '0;
    prev_exp[1] = '0;
  endtask

  task automatic test_directed();
    logic [7:0]  ta [3] = '{8'h5A, 8'hFF, 8'h7F};
    logic [7:0]  tb [3] = '{8'h3C, 8'h01, 8'h00};
    bit          tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  es [3] = '{8'h96, 8'h00, 8'h80};
    bit          ec [3] = '{1'b0, 1'b1, 1'b0};
    bit          eo [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] s;
    bit          co, ov, st;
    int          bn, dk, dn;
    for (int i = 0; i < 3; i++) begin
      run_op(0, 8, 32'(ta[i]), 32'(tb[i]), tc[i], s, co, ov, bn, dk, dn, st);
      checks++;
      if (s !== 32'(es[i]) || co !== ec[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL directed%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, s, co, ov, es[i], ec[i], eo[i]);
      end
      checks++;
      if (bn != 9 || dk != 9 || dn != 1) begin
        errors++;
        $display("FAIL directed%0d_timing got busy_cycles=%0d done_cycle=%0d done_width=%0d want 9 9 1",
                 i, bn, dk, dn);
      end
      prev_exp[0] = 32'(es[i]);
    end
  endtask

  task automatic test_start_held();
    int dks[$];
    drive(0, 1'b1, 32'h01, 32'h02, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done8) begin
        dks.push_back(k);
        checks++;
        if (sum8 !== 8'h03) begin
          errors++;
          $display("FAIL held_sum at cycle %0d got %h want 03", k, sum8);
        end
      end
      // Garbage while busy; correct operands whenever a start can be taken.
      if (busy8) drive(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
      else       drive(0, 1'b1, 32'h01, 32'h02, 1'b0);
    end
    drive(0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (dks.size() != 4) begin
      errors++;
      $display("FAIL held_count got %0d done pulses want 4", dks.size());
    end
    for (int i = 1; i < dks.size(); i++) begin
      checks++;
      if (dks[i] - dks[i-1] != 10) begin
        errors++;
        $display("FAIL held_gap%0d got %0d want 10", i, dks[i] - dks[i-1]);
      end
    end
    for (int k = 0; k < 15 && busy8; k++) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL held_drain got busy=%b want 0", busy8);
    end
    prev_exp[0] = 32'h03;
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    bit          co, ov, st;
    int          bn, dk, dn, seen;
    run_op(0, 8, 32'h5A, 32'h3C, 1'b0, s, co, ov, bn, dk, dn, st);
    prev_exp[0] = 32'h96;
    drive(0, 1'b1, 32'h11, 32'h22, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before got %b want 1", busy8);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, cout8, ovf8} !== 4'b0000 || sum8 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prev_exp[0] = '0;
    prev_exp[1] = '0;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d active cycles want 0", seen);
    end
    run_op(0, 8, 32'h10, 32'h20, 1'b0, s, co, ov, bn, dk, dn, st);
    checks++;
    if (s !== 32'h30 || co !== 1'b0 || ov !== 1'b0 || dn != 1 || !st) begin
      errors++;
      $display("FAIL mid_after got sum=%h cout=%b ovf=%b done_width=%0d stable=%b want 30 0 0 1 1",
               s, co, ov, dn, st);
    end
    prev_exp[0] = 32'h30;
  endtask

  task automatic test_random(input int d, input int w, input int n);
    logic [31:0] av, bv, m, s, es;
    bit          cv, co, ov, ec, eo, st;
    int          bn, dk, dn;
    m = (32'd1 << w) - 1;
    for (int i = 0; i < n; i++) begin
      // Bias toward corner operands now and then.
      case ($urandom_range(0, 7))
        0:       av = 0;
        1:       av = m;
        2:       av = 32'd1 << (w - 1);
        default: av = $urandom & m;
      endcase
      case ($urandom_range(0, 7))
        0:       bv = m;
        1:       bv = (32'd1 << (w - 1)) - 1;
        default: bv = $urandom & m;
      endcase
      cv = 1'($urandom_range(0, 1));
      model(w, av, bv, cv, es, ec, eo);
      run_op(d, w, av, bv, cv, s, co, ov, bn, dk, dn, st);
      checks++;
      if (s !== es || co !== ec || ov !== eo) begin
        errors++;
        $display("FAIL rand_w%0d_%0d a=%h b=%h cin=%b got sum=%h cout=%b ovf=%b want %h %b %b",
                 w, i, av, bv, cv, s, co, ov, es, ec, eo);
      end
      checks++;
      if (dn != 1 || dk != w + 1 || bn != w + 1) begin
        errors++;
        $display("FAIL rand_w%0d_%0d_timing got done_width=%0d done_cycle=%0d busy=%0d want 1 %0d %0d",
                 w, i, dn, dk, bn, w + 1, w + 1);
      end
      checks++;
      if (!st) begin
        errors++;
        $display("FAIL rand_w%0d_%0d_stable got sum moving before done want held %h",
                 w, i, prev_exp[d]);
      end
      prev_exp[d] = es;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_random(0, 8, 1000);
    test_random(1, 13, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_add_ctrl
